board_pos_tracker: RTL

- Parametrised multi-player position tracker for the ring-shaped game board.
- Generalises the single-player, fixed-24-tile, one-step counter to NUM_PLAYERS tokens on a RING_SIZE ring.
- Adds multi-step moves with a busy/done handshake, evenly spaced start positions for any player count, and landing-collision detection.
- Sits between the turn/dice controller (issues setup and move requests) and the display/score logic (consumes positions and hit events).

---
 rtl/board_pos_tracker.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/board_pos_tracker.sv
// board_pos_tracker: multi-player token position tracker for a ring board.
// Handles setup (evenly spaced starts via a repeated-subtraction divider),
// multi-step moves with a busy/done handshake, and landing-collision reporting.
// Optional lap counters are enabled by defining BOARD_LAP_COUNT_EN.
module board_pos_tracker #(
  parameter int NUM_PLAYERS = 4,
  parameter int RING_SIZE   = 24,
  parameter int POS_W       = 5,
  parameter int STEP_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         setup,
  input  logic [3:0]                   num_active,
  input  logic                         move_req,
  input  logic [2:0]                   move_player,
  input  logic [STEP_W-1:0]            move_steps,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         hit,
  output logic [2:0]                   hit_idx,
`ifdef BOARD_LAP_COUNT_EN
  output logic [NUM_PLAYERS*4-1:0]     laps_flat,
`endif
  output logic [NUM_PLAYERS*POS_W-1:0] pos_flat
);

  localparam int CNT_W = $clog2(RING_SIZE + 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(RING_SIZE - 1);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_PLAYERS - 1);

  typedef enum logic [1:0] {IDLE, DIV, PLACE, MOVE} state_t;

  // Advance one tile; the last tile wraps back to tile 0.
  function automatic logic [POS_W-1:0] ring_inc(input logic [POS_W-1:0] p);
    return (p == LAST_POS) ? '0 : p + 1'b1;
  endfunction

  // Clamp the requested player count into 2..NUM_PLAYERS.
  function automatic logic [3:0] clamp_n(input logic [3:0] na);
    if (na < 4'd2)                   return 4'd2;
    else if (na > 4'(NUM_PLAYERS))   return 4'(NUM_PLAYERS);
    else                             return na;
  endfunction

`ifdef BOARD_LAP_COUNT_EN
  // Lap counter increment, saturating at 15.
  function automatic logic [3:0] lap_inc(input logic [3:0] l);
    return (l == 4'hF) ? l : l + 4'd1;
  endfunction
`endif

  state_t              state, state_nx;
  logic [3:0]          n_lat;
  logic [CNT_W-1:0]    rem, q, acc, n_cnt;
  logic [2:0]          idx, player;
  logic [STEP_W-1:0]   steps_left;
  logic [POS_W-1:0]    pos [NUM_PLAYERS];
  logic [POS_W-1:0]    mover_pos, mover_next;
  logic                move_reject, idx_active, last_step, hit_nx;
  logic [2:0]          hit_idx_nx;
`ifdef BOARD_LAP_COUNT_EN
  logic [3:0]          laps [NUM_PLAYERS];
`endif

  assign n_cnt      = CNT_W'(n_lat);
  assign idx_active = ({1'b0, idx} < n_lat);
  assign last_step  = (steps_left <= STEP_W'(1));

  // Current and next tile of the moving token, plus lowest-index landing victim.
  always_comb begin
    mover_pos  = '0;
    hit_nx     = 1'b0;
    hit_idx_nx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (3'(i) == player) mover_pos = pos[i];
    mover_next = ring_inc(mover_pos);
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if ((4'(i) < n_lat) && (3'(i) != player) && (pos[i] == mover_next)) begin
        hit_nx     = 1'b1;
        hit_idx_nx = 3'(i);
      end
    end
  end

  // Next-state logic; setup outranks move_req and requests are only seen in IDLE.
  always_comb begin
    state_nx    = state;
    move_reject = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          state_nx = DIV;
        end else if (move_req) begin
          if ({1'b0, move_player} >= n_lat) move_reject = 1'b1;
          else                              state_nx    = MOVE;
        end
      end
      DIV:     if (rem < n_cnt) state_nx = PLACE;
      PLACE:   if (idx == LAST_IDX) state_nx = IDLE;
      MOVE:    if (last_step) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Registered handshake and event outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      hit     <= 1'b0;
      hit_idx <= '0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= ((state == PLACE) && (idx == LAST_IDX)) || ((state == MOVE) && last_step);
      err  <= move_reject;
      hit  <= (state == MOVE) && (steps_left == STEP_W'(1)) && hit_nx;
      if ((state == MOVE) && (steps_left == STEP_W'(1)) && hit_nx) hit_idx <= hit_idx_nx;
    end
  end

  // Divider, placement and move datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lat      <= '0;
      rem        <= '0;
      q          <= '0;
      acc        <= '0;
      idx        <= '0;
      player     <= '0;
      steps_left <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pos[i] <= '0;
`ifdef BOARD_LAP_COUNT_EN
        laps[i] <= '0;
`endif
      end
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            n_lat <= clamp_n(num_active);
            rem   <= CNT_W'(RING_SIZE);
            q     <= '0;
          end else if (move_req && !move_reject) begin
            player     <= move_player;
            steps_left <= move_steps;
          end
        end
        DIV: begin
          if (rem >= n_cnt) begin
            rem <= rem - n_cnt;
            q   <= q + 1'b1;
          end else begin
            idx <= '0;
            acc <= '0;
          end
        end
        PLACE: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (3'(i) == idx) begin
              pos[i] <= idx_active ? POS_W'(acc) : '0;
`ifdef BOARD_LAP_COUNT_EN
              laps[i] <= '0;
`endif
            end
          end
          if (idx_active) acc <= acc + q;
          idx <= idx + 1'b1;
        end
        MOVE: begin
          if (steps_left != '0) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              if (3'(i) == player) begin
                pos[i] <= mover_next;
`ifdef BOARD_LAP_COUNT_EN
                if (mover_pos == LAST_POS) laps[i] <= lap_inc(laps[i]);
`endif
              end
            end
            steps_left <= steps_left - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_flat
    assign pos_flat[g*POS_W +: POS_W] = pos[g];
`ifdef BOARD_LAP_COUNT_EN
    assign laps_flat[g*4 +: 4] = laps[g];
`endif
  end

endmodule
